// File: rtl/eight_bit_shift_register.sv
// Serial-in, parallel-out shift register: one bit per rising clk edge enters at bit 0,
// older bits move toward the MSB and bit WIDTH-1 falls off the end.
module eight_bit_shift_register #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = {shift_q[WIDTH-2:0], data_in};
    end

    // Reset is active-low and asynchronous, so it overrides a coincident clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= RESET_VALUE;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign data_out = shift_q;

endmodule

// File: tb/tb_eight_bit_shift_register.sv
// Self-checking bench for eight_bit_shift_register: directed scenarios plus random
// serial traffic compared against a bit-history queue model.
module tb_eight_bit_shift_register;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         data_in;
    logic [W-1:0] data_out;

    int n_checks;
    int n_fail;

    // Newest bit at index 0; only the last W bits are kept.
    bit history[$];

    eight_bit_shift_register #(
        .WIDTH      (W),
        .RESET_VALUE('0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_value();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < history.size(); k++) begin
            if (history[k]) v = v + (W'(1) << k);
        end
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Present a bit, take one edge, sample 1 time unit later.
    task automatic shift_bit(input bit b);
        data_in = b;
        @(posedge clk);
        #1;
        if (reset) begin
            history.push_front(b);
            if (history.size() > W) void'(history.pop_back());
        end
        check_eq("shift", data_out, model_value());
    endtask

    task automatic shift_seq(input logic [W-1:0] bits_msb_first);
        logic [W-1:0] tmp;
        tmp = bits_msb_first;
        for (int i = W - 1; i >= 0; i--) shift_bit(tmp[i]);
    endtask

    // Assert reset between edges, hold across one edge, release before the next edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        history.delete();
        check_eq("rst_async", data_out, '0);
        @(posedge clk);
        #1;
        check_eq("rst_hold", data_out, '0);
        reset = 1'b1;
        #1;
        check_eq("rst_release", data_out, '0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        data_in  = 1'b1;

        // Power-up: held in reset with data_in = 1 for 3 edges.
        #1;
        check_eq("por_initial", data_out, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("por_hold", data_out, '0);
        end

        // Release with data_in = 1 and no edge: still zero until the first edge.
        reset = 1'b1;
        #2;
        check_eq("release_noedge", data_out, '0);
        shift_bit(1'b1);
        check_eq("release_first", data_out, 8'h01);

        // Basic shift 1,0,1,1 from reset.
        pulse_reset();
        shift_bit(1'b1); check_eq("basic_01", data_out, 8'h01);
        shift_bit(1'b0); check_eq("basic_02", data_out, 8'h02);
        shift_bit(1'b1); check_eq("basic_05", data_out, 8'h05);
        shift_bit(1'b1); check_eq("basic_0b", data_out, 8'h0B);

        // Fill and overflow.
        pulse_reset();
        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        check_eq("fill_ff", data_out, 8'hFF);
        shift_bit(1'b0);
        check_eq("fill_fe", data_out, 8'hFE);
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        check_eq("drain_00", data_out, 8'h00);

        // Asynchronous reset midway between edges from 0xA5.
        shift_seq(8'hA5);
        check_eq("pre_a5", data_out, 8'hA5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        history.delete();
        check_eq("mid_async", data_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        shift_bit(1'b1);
        check_eq("mid_after", data_out, 8'h01);

        // Pattern check.
        pulse_reset();
        shift_seq(8'b0110_0110);
        check_eq("pat_66", data_out, 8'h66);
        shift_seq(8'b0101_1000);
        check_eq("pat_58", data_out, 8'h58);

        // Reset asserted exactly at a rising edge wins over the shift.
        data_in = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        #1;
        history.delete();
        check_eq("rst_at_edge", data_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
            end else begin
                shift_bit(1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eight_bit_shift_register.md
Name: eight_bit_shift_register

Overview:
Serial-in, parallel-out (SIPO) shift register, default width 8 bits. Samples one serial bit per rising clock edge and shifts it into the LSB of the parallel output word; older bits move toward the MSB. Used as a serial-to-parallel front end for byte-wide consumers. The full register is visible every cycle. There is no framing or valid flag.

Parameters:
- WIDTH, 8, number of stages and width of data_out; legal values are 2 or more.
- RESET_VALUE, all zeros (WIDTH bits), value loaded into the register while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears the register immediately; 1 means normal operation.
- data_in  input  1  serial input bit, sampled on the rising edge of clk.
- data_out  output  WIDTH  parallel register contents. Bit 0 is the newest bit; bit WIDTH-1 is the oldest.

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on port reset.
- Reset assertion (reset = 0):
  - data_out becomes RESET_VALUE (0x00 by default) immediately.
  - No clock edge is needed.
  - The value holds for as long as reset stays 0, regardless of clk and data_in.
- Reset release (0 to 1): the register holds RESET_VALUE until the first rising clk edge. That edge performs a normal shift.
- Each rising clk edge with reset = 1 performs data_out_next = {data_out[WIDTH-2:0], data_in}:
  - data_in goes into bit 0.
  - Bit WIDTH-1 is discarded.
- There is no enable. A shift happens on every edge while out of reset.
- Latency: a bit presented before edge N appears at data_out[0] right after edge N. It reaches data_out[k] after edge N+k and leaves the register after edge N+WIDTH.
- data_out is driven directly from the flops; there is no combinational path from data_in to data_out.
- Reset mid-operation: contents are lost and the register restarts from RESET_VALUE. Partially shifted data is not preserved.
- Reset and a clk edge at the same moment: reset wins, and data_out = RESET_VALUE.
- X or Z on data_in is not handled specially; it propagates like any other bit.

Test Plan:
- Power-up reset: hold reset = 0 and toggle clk with data_in = 1 for 3 cycles -> data_out stays 0x00 throughout.
- Basic shift: release reset, then shift in 1,0,1,1 on 4 consecutive edges -> data_out reads 0x01, 0x02, 0x05, 0x0B after each edge.
- Fill and overflow:
  - Shift 8 ones from reset -> data_out = 0xFF.
  - Then shift one 0 -> 0xFE.
  - Then 7 more zeros -> 0x00, showing the MSB is discarded.
- Asynchronous reset mid-stream:
  - With data_out = 0xA5, drive reset = 0 midway between clk edges -> data_out = 0x00 before the next rising edge.
  - Releasing reset and shifting 1 -> 0x01.
- Pattern check: from reset, shift the sequence 0,1,1,0,0,1,1,0 (first bit first) -> data_out = 0x66.
  - Continue with 0,1,0,1,1,0,0,0 -> data_out = 0x58.
- Release timing: drive reset 0 to 1 with data_in = 1, with no clk edge in between -> data_out remains 0x00 until the first edge, then reads 0x01.
